// File: rtl/xfcp_route_pkg.sv
// Shared state encodings, port limit and width helper for the XFCP route demux.
// Used by xfcp_rr_arbiter and xfcp_route_demux.
package xfcp_route_pkg;

    localparam int MAX_PORTS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } req_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_HDR  = 2'd1,
        R_DATA = 2'd2
    } rsp_state_e;

    // Index width for a port count; a single port still needs one bit.
    function automatic int sel_width(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/xfcp_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after last_grant,
// wrapping from PORTS-1 back to 0, so last_grant itself has lowest priority.
import xfcp_route_pkg::*;

module xfcp_rr_arbiter #(
    parameter int PORTS = 4,
    parameter int SEL_W = sel_width(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [SEL_W-1:0] last_grant,
    output logic [SEL_W-1:0] grant,
    output logic             valid
);

    // Priority scan starting one past the previous winner.
    always_comb begin
        int idx;
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 1; i <= PORTS; i++) begin
            idx = (int'(last_grant) + i) % PORTS;
            if (!valid && req[idx]) begin
                grant = idx[SEL_W-1:0];
                valid = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/xfcp_route_demux.sv
// XFCP route demux: strips a route byte to steer requests, tags responses with a port header.
// Optional drop statistics counter enabled by macro XFCP_ROUTE_STATS_EN.
import xfcp_route_pkg::*;

module xfcp_route_demux #(
    parameter int PORTS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         up_xfcp_in_tdata,
    input  logic               up_xfcp_in_tvalid,
    output logic               up_xfcp_in_tready,
    input  logic               up_xfcp_in_tlast,
    input  logic               up_xfcp_in_tuser,
    output logic [7:0]         up_xfcp_out_tdata,
    output logic               up_xfcp_out_tvalid,
    input  logic               up_xfcp_out_tready,
    output logic               up_xfcp_out_tlast,
    output logic               up_xfcp_out_tuser,
    output logic [PORTS*8-1:0] down_xfcp_out_tdata,
    output logic [PORTS-1:0]   down_xfcp_out_tvalid,
    input  logic [PORTS-1:0]   down_xfcp_out_tready,
    output logic [PORTS-1:0]   down_xfcp_out_tlast,
    output logic [PORTS-1:0]   down_xfcp_out_tuser,
    input  logic [PORTS*8-1:0] down_xfcp_in_tdata,
    input  logic [PORTS-1:0]   down_xfcp_in_tvalid,
    output logic [PORTS-1:0]   down_xfcp_in_tready,
    input  logic [PORTS-1:0]   down_xfcp_in_tlast,
    input  logic [PORTS-1:0]   down_xfcp_in_tuser,
    output logic [15:0]        drop_count
);

    localparam int SEL_W = sel_width(PORTS);

    req_state_e       req_state_r, req_next_s;
    rsp_state_e       rsp_state_r, rsp_next_s;
    logic [SEL_W-1:0] sel_r, grant_r, last_grant_r, arb_grant_s;
    logic             arb_valid_s, route_ok_s, sel_load_s, rsp_done_s;

    assign route_ok_s = int'(up_xfcp_in_tdata) < PORTS;
    assign sel_load_s = (req_state_r == IDLE) && up_xfcp_in_tvalid && !up_xfcp_in_tlast && route_ok_s;

    // Request direction: route byte decode, then pass-through or discard.
    always_comb begin
        req_next_s           = req_state_r;
        up_xfcp_in_tready    = 1'b0;
        down_xfcp_out_tdata  = '0;
        down_xfcp_out_tvalid = '0;
        down_xfcp_out_tlast  = '0;
        down_xfcp_out_tuser  = '0;
        case (req_state_r)
            IDLE: begin
                up_xfcp_in_tready = 1'b1;
                if (up_xfcp_in_tvalid && !up_xfcp_in_tlast) begin
                    req_next_s = route_ok_s ? FWD : DROP;
                end else begin
                    req_next_s = IDLE;
                end
            end
            FWD: begin
                for (int k = 0; k < PORTS; k++) begin
                    if (k == int'(sel_r)) begin
                        down_xfcp_out_tdata[k*8 +: 8] = up_xfcp_in_tdata;
                        down_xfcp_out_tvalid[k]       = up_xfcp_in_tvalid;
                        down_xfcp_out_tlast[k]        = up_xfcp_in_tlast;
                        down_xfcp_out_tuser[k]        = up_xfcp_in_tuser;
                        up_xfcp_in_tready             = down_xfcp_out_tready[k];
                    end else begin
                        down_xfcp_out_tvalid[k] = 1'b0;
                    end
                end
                if (up_xfcp_in_tvalid && down_xfcp_out_tready[sel_r] && up_xfcp_in_tlast) begin
                    req_next_s = IDLE;
                end else begin
                    req_next_s = FWD;
                end
            end
            DROP: begin
                up_xfcp_in_tready = 1'b1;
                if (up_xfcp_in_tvalid && up_xfcp_in_tlast) begin
                    req_next_s = IDLE;
                end else begin
                    req_next_s = DROP;
                end
            end
            default: begin
                req_next_s = IDLE;
            end
        endcase
    end

    // Request state and selected port register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_state_r <= IDLE;
            sel_r       <= '0;
        end else begin
            req_state_r <= req_next_s;
            if (sel_load_s) begin
                sel_r <= up_xfcp_in_tdata[SEL_W-1:0];
            end
        end
    end

    xfcp_rr_arbiter #(
        .PORTS (PORTS),
        .SEL_W (SEL_W)
    ) u_arb (
        .req        (down_xfcp_in_tvalid),
        .last_grant (last_grant_r),
        .grant      (arb_grant_s),
        .valid      (arb_valid_s)
    );

    // Response direction: arbitrate, emit header byte, then pass-through from the winner.
    always_comb begin
        rsp_next_s          = rsp_state_r;
        rsp_done_s          = 1'b0;
        up_xfcp_out_tdata   = '0;
        up_xfcp_out_tvalid  = 1'b0;
        up_xfcp_out_tlast   = 1'b0;
        up_xfcp_out_tuser   = 1'b0;
        down_xfcp_in_tready = '0;
        case (rsp_state_r)
            R_IDLE: begin
                if (arb_valid_s) begin
                    rsp_next_s = R_HDR;
                end else begin
                    rsp_next_s = R_IDLE;
                end
            end
            R_HDR: begin
                up_xfcp_out_tdata  = {{(8-SEL_W){1'b0}}, grant_r};
                up_xfcp_out_tvalid = 1'b1;
                if (up_xfcp_out_tready) begin
                    rsp_next_s = R_DATA;
                end else begin
                    rsp_next_s = R_HDR;
                end
            end
            R_DATA: begin
                for (int k = 0; k < PORTS; k++) begin
                    if (k == int'(grant_r)) begin
                        up_xfcp_out_tdata      = down_xfcp_in_tdata[k*8 +: 8];
                        up_xfcp_out_tvalid     = down_xfcp_in_tvalid[k];
                        up_xfcp_out_tlast      = down_xfcp_in_tlast[k];
                        up_xfcp_out_tuser      = down_xfcp_in_tuser[k];
                        down_xfcp_in_tready[k] = up_xfcp_out_tready;
                    end else begin
                        down_xfcp_in_tready[k] = 1'b0;
                    end
                end
                if (down_xfcp_in_tvalid[grant_r] && up_xfcp_out_tready && down_xfcp_in_tlast[grant_r]) begin
                    rsp_next_s = R_IDLE;
                    rsp_done_s = 1'b1;
                end else begin
                    rsp_next_s = R_DATA;
                end
            end
            default: begin
                rsp_next_s = R_IDLE;
            end
        endcase
    end

    // Response state, current grant and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_state_r  <= R_IDLE;
            grant_r      <= '0;
            last_grant_r <= SEL_W'(PORTS - 1);
        end else begin
            rsp_state_r <= rsp_next_s;
            if (rsp_state_r == R_IDLE && arb_valid_s) begin
                grant_r <= arb_grant_s;
            end
            if (rsp_done_s) begin
                last_grant_r <= grant_r;
            end
        end
    end

`ifdef XFCP_ROUTE_STATS_EN
    logic        drop_inc_s;
    logic [15:0] drop_count_r;

    // A drop is decided on the route byte: either it ends the packet or names no port.
    assign drop_inc_s = (req_state_r == IDLE) && up_xfcp_in_tvalid && (up_xfcp_in_tlast || !route_ok_s);

    // Saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_r <= 16'd0;
        end else if (drop_inc_s && drop_count_r != 16'hFFFF) begin
            drop_count_r <= drop_count_r + 16'd1;
        end
    end

    assign drop_count = drop_count_r;
`else
    assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_xfcp_route_demux.sv
// Directed self-checking bench for xfcp_route_demux with PORTS=4; inputs change on the
// falling edge and outputs are sampled 1ns later, away from the rising edge.
module tb_xfcp_route_demux;

    localparam int PORTS = 4;
`ifdef XFCP_ROUTE_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [7:0]         up_xfcp_in_tdata;
    logic               up_xfcp_in_tvalid, up_xfcp_in_tready, up_xfcp_in_tlast, up_xfcp_in_tuser;
    logic [7:0]         up_xfcp_out_tdata;
    logic               up_xfcp_out_tvalid, up_xfcp_out_tready, up_xfcp_out_tlast, up_xfcp_out_tuser;
    logic [PORTS*8-1:0] down_xfcp_out_tdata, down_xfcp_in_tdata;
    logic [PORTS-1:0]   down_xfcp_out_tvalid, down_xfcp_out_tready, down_xfcp_out_tlast, down_xfcp_out_tuser;
    logic [PORTS-1:0]   down_xfcp_in_tvalid, down_xfcp_in_tready, down_xfcp_in_tlast, down_xfcp_in_tuser;
    logic [15:0]        drop_count;

    int n_chk = 0;
    int n_bad = 0;

    xfcp_route_demux #(.PORTS(PORTS)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .up_xfcp_in_tdata     (up_xfcp_in_tdata),
        .up_xfcp_in_tvalid    (up_xfcp_in_tvalid),
        .up_xfcp_in_tready    (up_xfcp_in_tready),
        .up_xfcp_in_tlast     (up_xfcp_in_tlast),
        .up_xfcp_in_tuser     (up_xfcp_in_tuser),
        .up_xfcp_out_tdata    (up_xfcp_out_tdata),
        .up_xfcp_out_tvalid   (up_xfcp_out_tvalid),
        .up_xfcp_out_tready   (up_xfcp_out_tready),
        .up_xfcp_out_tlast    (up_xfcp_out_tlast),
        .up_xfcp_out_tuser    (up_xfcp_out_tuser),
        .down_xfcp_out_tdata  (down_xfcp_out_tdata),
        .down_xfcp_out_tvalid (down_xfcp_out_tvalid),
        .down_xfcp_out_tready (down_xfcp_out_tready),
        .down_xfcp_out_tlast  (down_xfcp_out_tlast),
        .down_xfcp_out_tuser  (down_xfcp_out_tuser),
        .down_xfcp_in_tdata   (down_xfcp_in_tdata),
        .down_xfcp_in_tvalid  (down_xfcp_in_tvalid),
        .down_xfcp_in_tready  (down_xfcp_in_tready),
        .down_xfcp_in_tlast   (down_xfcp_in_tlast),
        .down_xfcp_in_tuser   (down_xfcp_in_tuser),
        .drop_count           (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One upstream beat with all downstream tready high; p<0 means no port may see it.
    task automatic up_beat(input logic [7:0] d, input logic l, input int p, input string tag);
        @(negedge clk);
        up_xfcp_in_tdata  = d;
        up_xfcp_in_tlast  = l;
        up_xfcp_in_tvalid = 1'b1;
        #1;
        check({tag, "_rdy"}, 32'(up_xfcp_in_tready), 32'd1);
        if (p < 0) begin
            check({tag, "_vld"}, 32'(down_xfcp_out_tvalid), 32'd0);
        end else begin
            check({tag, "_vld"}, 32'(down_xfcp_out_tvalid), 32'd1 << p);
            check({tag, "_dat"}, 32'(down_xfcp_out_tdata[p*8 +: 8]), 32'(d));
            check({tag, "_lst"}, 32'(down_xfcp_out_tlast), 32'(l) << p);
        end
        @(posedge clk);
    endtask

    // Expect one response packet (header + single last beat) from port p; source already valid.
    task automatic rsp_pkt(input int p, input logic [7:0] d, input logic u, input string tag);
        @(posedge clk);
        @(negedge clk);
        #1;
        check({tag, "_hvld"}, 32'(up_xfcp_out_tvalid), 32'd1);
        check({tag, "_hdat"}, 32'(up_xfcp_out_tdata), 32'(p));
        check({tag, "_hlst"}, 32'(up_xfcp_out_tlast), 32'd0);
        check({tag, "_husr"}, 32'(up_xfcp_out_tuser), 32'd0);
        check({tag, "_hrdy"}, 32'(down_xfcp_in_tready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check({tag, "_dvld"}, 32'(up_xfcp_out_tvalid), 32'd1);
        check({tag, "_ddat"}, 32'(up_xfcp_out_tdata), 32'(d));
        check({tag, "_dlst"}, 32'(up_xfcp_out_tlast), 32'd1);
        check({tag, "_dusr"}, 32'(up_xfcp_out_tuser), 32'(u));
        check({tag, "_drdy"}, 32'(down_xfcp_in_tready), 32'd1 << p);
        @(posedge clk);
        @(negedge clk);
        down_xfcp_in_tvalid[p] = 1'b0;
        #1;
        check({tag, "_idle"}, 32'(up_xfcp_out_tvalid), 32'd0);
    endtask

    initial begin
        rst_n                = 1'b0;
        up_xfcp_in_tdata     = 8'h00;
        up_xfcp_in_tvalid    = 1'b0;
        up_xfcp_in_tlast     = 1'b0;
        up_xfcp_in_tuser     = 1'b0;
        up_xfcp_out_tready   = 1'b1;
        down_xfcp_out_tready = 4'hF;
        down_xfcp_in_tdata   = 32'h0;
        down_xfcp_in_tvalid  = 4'h0;
        down_xfcp_in_tlast   = 4'h0;
        down_xfcp_in_tuser   = 4'h0;
        #1;
        check("rst_in_rdy", 32'(up_xfcp_in_tready), 32'd1);
        check("rst_dn_vld", 32'(down_xfcp_out_tvalid), 32'd0);
        check("rst_up_vld", 32'(up_xfcp_out_tvalid), 32'd0);
        check("rst_dn_rdy", 32'(down_xfcp_in_tready), 32'd0);
        check("rst_drops", 32'(drop_count), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Forward 02 AA BB CC -> port 2
        up_beat(8'h02, 1'b0, -1, "f_route");
        up_beat(8'hAA, 1'b0, 2, "f_aa");
        up_beat(8'hBB, 1'b0, 2, "f_bb");
        up_beat(8'hCC, 1'b1, 2, "f_cc");

        // Out-of-range route 07 is dropped, then 00 55 reaches port 0
        up_beat(8'h07, 1'b0, -1, "d_route");
        up_beat(8'h11, 1'b0, -1, "d_11");
        check("drops_1", 32'(drop_count), 32'(STATS));
        up_beat(8'h22, 1'b1, -1, "d_22");
        up_beat(8'h00, 1'b0, -1, "p0_route");
        up_beat(8'h55, 1'b1, 0, "p0_55");
        // Single-byte packet is dropped; route 04 is first illegal; 03 is last legal
        up_beat(8'h01, 1'b1, -1, "d_single");
        up_beat(8'h04, 1'b0, -1, "d_route4");
        up_beat(8'hEE, 1'b1, -1, "d_ee");
        check("drops_3", 32'(drop_count), 32'(3 * STATS));
        up_beat(8'h03, 1'b0, -1, "p3_route");
        up_beat(8'h77, 1'b1, 3, "p3_77");

        // Backpressure on port 2: tready 1,0,0,1
        up_beat(8'h02, 1'b0, -1, "bp_route");
        @(negedge clk);
        up_xfcp_in_tdata = 8'hD0; up_xfcp_in_tlast = 1'b0; down_xfcp_out_tready = 4'b0100;
        #1;
        check("bp_rdy1", 32'(up_xfcp_in_tready), 32'd1);
        check("bp_dat1", 32'(down_xfcp_out_tdata[23:16]), 32'h0D0);
        @(negedge clk);
        up_xfcp_in_tdata = 8'hD1; up_xfcp_in_tlast = 1'b1; down_xfcp_out_tready = 4'b1011;
        #1;
        check("bp_rdy2", 32'(up_xfcp_in_tready), 32'd0);
        check("bp_vld2", 32'(down_xfcp_out_tvalid), 32'b0100);
        @(negedge clk);
        #1;
        check("bp_rdy3", 32'(up_xfcp_in_tready), 32'd0);
        check("bp_dat3", 32'(down_xfcp_out_tdata[23:16]), 32'h0D1);
        @(negedge clk);
        down_xfcp_out_tready = 4'hF;
        #1;
        check("bp_rdy4", 32'(up_xfcp_in_tready), 32'd1);
        check("bp_dat4", 32'(down_xfcp_out_tdata[23:16]), 32'h0D1);
        check("bp_lst4", 32'(down_xfcp_out_tlast), 32'b0100);
        @(negedge clk);
        up_xfcp_in_tvalid = 1'b0; up_xfcp_in_tlast = 1'b0;
        #1;
        check("bp_done", 32'(down_xfcp_out_tvalid), 32'd0);

        // Responses: ports 1 and 3 both pending, two rounds
        down_xfcp_in_tdata = {8'h9A, 8'h22, 8'h9A, 8'h11};
        down_xfcp_in_tlast = 4'hF;
        down_xfcp_in_tuser = 4'b1000;
        down_xfcp_in_tvalid = 4'b1010;
        #1;
        check("rr_grant_cyc", 32'(up_xfcp_out_tvalid), 32'd0);
        rsp_pkt(1, 8'h9A, 1'b0, "rr1_p1");
        rsp_pkt(3, 8'h9A, 1'b1, "rr1_p3");
        @(negedge clk);
        down_xfcp_in_tvalid = 4'b1010;
        rsp_pkt(1, 8'h9A, 1'b0, "rr2_p1");
        rsp_pkt(3, 8'h9A, 1'b1, "rr2_p3");

        // Reset mid-response after header 02
        @(negedge clk);
        down_xfcp_in_tdata[23:16] = 8'h3C;
        down_xfcp_in_tlast  = 4'h0;
        down_xfcp_in_tuser  = 4'h0;
        down_xfcp_in_tvalid = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("mr_hdat", 32'(up_xfcp_out_tdata), 32'd2);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("mr_ddat", 32'(up_xfcp_out_tdata), 32'h03C);
        rst_n = 1'b0;
        #1;
        check("mr_rst_vld", 32'(up_xfcp_out_tvalid), 32'd0);
        check("mr_rst_rdy", 32'(down_xfcp_in_tready), 32'd0);
        check("mr_rst_inrdy", 32'(up_xfcp_in_tready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        down_xfcp_in_tlast = 4'b0100;
        rsp_pkt(2, 8'h3C, 1'b0, "mr_fresh");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
